// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: bundles the pipeline-side access port and the backing-memory
// beat port of the data cache controller.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : memory-stage access (pipeline -> cache)
//   cpu_rdata/stall                   : load data and pipeline freeze (cache -> pipeline)
//   mem_req/mem_we/mem_addr/mem_wdata : beat request (cache -> memory)
//   mem_ready/mem_rdata               : beat completion and read data (memory -> cache)
// Modport slave is the cache's view; master is the surrounding system's view.
interface dcache_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// Load hits return data in the same cycle; load misses refill a 4-word line
// one beat at a time; every store is written through as a single beat.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : dcache_ctrl_if.slave (pipeline access port + backing-memory port)
// stall and cpu_rdata are combinational; all mem_* outputs are registered.
module dcache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned OW = $clog2(WORDS);
  localparam int unsigned TW = 32 - 2 - OW - IW;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_e;

  // Cache storage: only valid bits are reset.
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  state_e        state_q, state_d;
  logic [OW-1:0] beat_q, beat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [OW-1:0] off_q, off_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          stall_c;
  logic [31:0]   rdata_c;
  logic          inval_c;   // clear valid of the missing line
  logic          fill_c;    // write one refill beat into the line
  logic          done_c;    // last refill beat: install tag, set valid
  logic          upd_c;     // write-through store hit: update cached word

  // Request address decode.
  logic [OW-1:0] cpu_off_c;
  logic [IW-1:0] cpu_idx_c;
  logic [TW-1:0] cpu_tag_c;
  logic          hit_c;
  logic          unused_addr_c;

  assign cpu_off_c     = bus.cpu_addr[2 +: OW];
  assign cpu_idx_c     = bus.cpu_addr[2+OW +: IW];
  assign cpu_tag_c     = bus.cpu_addr[31 -: TW];
  assign unused_addr_c = ^bus.cpu_addr[1:0];
  assign hit_c         = bus.cpu_req & valid_q[cpu_idx_c] & (tag_mem[cpu_idx_c] == cpu_tag_c);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_c     = 1'b0;
    rdata_c     = '0;
    inval_c     = 1'b0;
    fill_c      = 1'b0;
    done_c      = 1'b0;
    upd_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            stall_c     = 1'b1;
            idx_d       = cpu_idx_c;
            tag_d       = cpu_tag_c;
            off_d       = cpu_off_c;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
            mem_wdata_d = bus.cpu_wdata;
            state_d     = WRITE;
          end else if (hit_c) begin
            rdata_c = data_mem[cpu_idx_c][cpu_off_c];
          end else begin
            // Invalidate now so an aborted refill never leaves a half-filled valid line.
            stall_c    = 1'b1;
            inval_c    = 1'b1;
            idx_d      = cpu_idx_c;
            tag_d      = cpu_tag_c;
            beat_d     = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_tag_c, cpu_idx_c, {OW{1'b0}}, 2'b00};
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          fill_c     = 1'b1;
          beat_d     = beat_q + OW'(1);
          mem_addr_d = {tag_q, idx_q, beat_d, 2'b00};
          if (beat_q == OW'(WORDS - 1)) begin
            done_c    = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      WRITE: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          upd_c     = valid_q[idx_q] & (tag_mem[idx_q] == tag_q);
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = WDONE;
        end
      end

      // Store retires here; the held request is not looked at again.
      WDONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Control and memory-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inval_c) valid_q[cpu_idx_c] <= 1'b0;
      if (done_c)  valid_q[idx_q]     <= 1'b1;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (fill_c) data_mem[idx_q][beat_q] <= bus.mem_rdata;
    if (done_c) tag_mem[idx_q]          <= tag_q;
    if (upd_c)  data_mem[idx_q][off_q]  <= mem_wdata_q;
  end

  assign bus.stall     = stall_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the driver predicts each access with a
// line-level reference cache (valid/tag per index) and a word-level reference
// memory, pushing the expected response and expected memory beats; a monitor
// and a memory responder pop and compare as the DUT presents them.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          beats;
    int          stall;
    bit          exact;
  } txn_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  txn_t  exp_q[$];
  beat_t beat_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int stall_cnt = 0;
  int ready_mode = 0;   // 0: always ready, 1: every other cycle, 2: random
  bit toggle = 1'b0;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  bit          ref_valid [16];
  logic [23:0] ref_tag   [16];

  function automatic logic [31:0] dflt(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: decide hit/miss at line granularity, predict data and beats.
  function automatic void model_issue(bit we, logic [31:0] a, logic [31:0] wd);
    txn_t        t;
    beat_t       b;
    int          idx;
    logic [23:0] tg;
    logic [31:0] wa;
    idx = int'(a[7:4]);
    tg  = a[31:8];
    wa  = {a[31:2], 2'b00};
    t.we = we;
    t.addr = wa;
    t.exact = (ready_mode == 0);
    t.data = '0;
    if (we) begin
      t.beats = 1;
      t.stall = 2;
      b.we = 1'b1; b.addr = wa; b.data = wd;
      beat_q.push_back(b);
      ref_mem[wa] = wd;
    end else if (ref_valid[idx] && ref_tag[idx] == tg) begin
      t.beats = 0;
      t.stall = 0;
      t.data = ref_rd(wa);
    end else begin
      t.beats = 4;
      t.stall = 5;
      t.data = ref_rd(wa);
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b0; b.addr = {wa[31:4], 4'h0} + 32'(k * 4); b.data = '0;
        beat_q.push_back(b);
      end
    end
    exp_q.push_back(t);
  endfunction

  // Issue one access and hold it until the monitor sees it retire.
  task automatic do_req(bit we, logic [31:0] a, logic [31:0] wd);
    int start;
    bit ok;
    @(posedge clk); #1;
    model_issue(we, a, wd);
    start = done_cnt;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = wd;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
    #1;
    bus.cpu_req = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL req_timeout: addr %h we %0d never retired", a, we);
      exp_q.delete();
      beat_q.delete();
    end
  endtask

  // Monitor: count stall cycles, compare on retirement.
  always @(negedge clk) begin
    txn_t t;
    if (!rst && bus.cpu_req) begin
      if (bus.stall) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: addr %h got nothing want no retirement", bus.cpu_addr);
        end else begin
          t = exp_q.pop_front();
          if (!t.we) check("load_data", bus.cpu_rdata, t.data);
          check("beat_count", 32'(beat_cnt), 32'(t.beats));
          if (t.exact) check("stall_cycles", 32'(stall_cnt), 32'(t.stall));
          else begin
            total++;
            if (stall_cnt < t.stall) begin
              bad++;
              $display("FAIL stall_min: got %0d want >= %0d", stall_cnt, t.stall);
            end
          end
        end
        stall_cnt = 0;
        beat_cnt = 0;
        done_cnt++;
      end
    end
  end

  // Backing-memory responder: decide ready, check each accepted beat.
  always @(negedge clk) begin
    beat_t b;
    bit go;
    bus.mem_ready = 1'b0;
    if (!rst && bus.mem_req) begin
      toggle = ~toggle;
      case (ready_mode)
        0:       go = 1'b1;
        1:       go = toggle;
        default: go = 1'($urandom_range(0, 1));
      endcase
      if (go) begin
        bus.mem_ready = 1'b1;
        beat_cnt++;
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: addr %h we %0d want no beat", bus.mem_addr, bus.mem_we);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr", bus.mem_addr, b.addr);
          check("beat_we", 32'(bus.mem_we), 32'(b.we));
          if (b.we) check("beat_wdata", bus.mem_wdata, b.data);
        end
        if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = mem_rd(bus.mem_addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
    mem_store[32'h100] = 32'hAAAA_0001; ref_mem[32'h100] = 32'hAAAA_0001;
    mem_store[32'h104] = 32'hBBBB_0002; ref_mem[32'h104] = 32'hBBBB_0002;
    mem_store[32'h108] = 32'hCCCC_0003; ref_mem[32'h108] = 32'hCCCC_0003;
    mem_store[32'h10C] = 32'hDDDD_0004; ref_mem[32'h10C] = 32'hDDDD_0004;

    rst = 1'b1;
    #2;
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    @(negedge clk); @(negedge clk); #2;
    rst = 1'b0;

    // Directed sequence, memory always ready.
    ready_mode = 0;
    do_req(1'b0, 32'h0000_0104, '0);       // miss -> refill, returns B
    do_req(1'b0, 32'h0000_0100, '0);       // hit A
    do_req(1'b0, 32'h0000_010C, '0);       // hit D
    do_req(1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h0000_0108, '0);       // hit, updated word
    do_req(1'b1, 32'h0000_2000, 32'h1234_5678);  // store miss, no allocate
    do_req(1'b0, 32'h0000_2000, '0);       // refill
    do_req(1'b0, 32'h0000_0104, '0);       // miss: evicted by 0x2000
    do_req(1'b0, 32'h0000_1104, '0);       // conflict evicts 0x104
    do_req(1'b0, 32'h0000_0104, '0);       // misses again

    // Reset during beat 2 of a throttled refill.
    ready_mode = 1;
    a = 32'h0000_3334;
    @(posedge clk); #1;
    model_issue(1'b0, a, '0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a; bus.cpu_wdata = '0;
    begin
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk);
        if (beat_cnt >= 2) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        total++; bad++;
        $display("FAIL refill_progress: got %0d beats want 2", beat_cnt);
      end
    end
    #1;
    check("mid_refill_addr", bus.mem_addr, 32'h0000_3338);
    check("mid_refill_req", 32'(bus.mem_req), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'h0);
    bus.cpu_req = 1'b0;
    #1;
    check("abort_stall", 32'(bus.stall), 32'h0);
    check("abort_mem_addr", bus.mem_addr, 32'h0);
    exp_q.delete();
    beat_q.delete();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    beat_cnt = 0;
    stall_cnt = 0;
    @(negedge clk); #2;
    rst = 1'b0;
    do_req(1'b0, a, '0);                   // full 4-beat refill again
    do_req(1'b0, a, '0);                   // now hits

    // Randomized mix over a small tag set to force hits, conflicts and stores.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      bit          rw;
      ready_mode = int'($urandom_range(0, 2));
      ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      rw = ($urandom_range(0, 3) == 0);
      do_req(rw, ra, $urandom);
    end

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("beat_q_drained", 32'(beat_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller sitting between the pipeline's memory-access stage and the backing data memory. It takes the registered ALU result as the address and the memctr-formatted store word as write data, and returns a 32-bit load word to memsel. It stalls the pipeline on read misses (4-beat line refill) and on every store (single-beat write-through).

## Interface
- LINES, 16, number of cache lines (power of two; index width IW = log2(LINES))
- WORDS, 4, 32-bit words per line (fixed at 4; offset = addr[3:2])
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cpu_req  input  1  memory-stage access valid (load or store)
- cpu_we  input  1  1 = store, 0 = load
- cpu_addr  input  32  byte address; bits [1:0] ignored
- cpu_wdata  input  32  store data
- cpu_rdata  output  32  load data, valid when cpu_req & ~cpu_we & ~stall
- stall  output  1  freeze pipeline; request must be held stable while high
- mem_req  output  1  backing-memory request, registered
- mem_we  output  1  1 = write beat, 0 = read beat
- mem_addr  output  32  word-aligned beat address
- mem_wdata  output  32  write data
- mem_ready  input  1  beat accepted/completed this cycle (ignored when mem_req = 0)
- mem_rdata  input  32  read data, valid with mem_ready on read beats

## Operation
- Address split: offset = addr[3:2], index = addr[4+IW-1:4], tag = addr[31:4+IW]. Storage: valid[LINES], tag[LINES], data[LINES][4].
- hit = cpu_req & valid[index] & (tag[index] == tag).
- States: IDLE, REFILL, WRITE, WDONE.
- IDLE: load hit -> cpu_rdata = data[index][offset] combinationally, stall = 0. Load miss -> stall = 1, latch tag/index, clear valid[index], beat = 0, go REFILL. Store -> stall = 1, latch addr/wdata, go WRITE. No request -> stall = 0, remain.
- REFILL: mem_req = 1, mem_we = 0, mem_addr = {tag, index, beat, 2'b00}. Each mem_ready writes mem_rdata into data[index][beat], beat++. On the beat-3 ready: write tag, set valid[index], go IDLE. The still-held load then hits.
- WRITE: mem_req = 1, mem_we = 1, mem_addr = latched address, mem_wdata = latched data. On mem_ready: if the line hits (valid & tag match), update data[index][offset]; go WDONE. Miss: no allocation, cache unchanged.
- WDONE: stall = 0 for exactly one cycle (store retires); the request is not re-evaluated; go IDLE.
- stall = (state == REFILL) | (state == WRITE) | (state == IDLE & cpu_req & (cpu_we | ~hit)).
- cpu_rdata outside a load hit: don't-care, driven 0.

## Timing
- Reset (async, immediate): state = IDLE, all valid = 0, beat = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_rdata = 0, stall = 0 (no request). Tag/data arrays are not reset.
- Load hit: 0 stall cycles, data same cycle.
- Load miss, mem_ready high every cycle: stall high for 5 cycles (IDLE detect + 4 REFILL); data returned in cycle 6. Each mem_ready gap adds one stall cycle.
- Store, mem_ready immediate: stall high for 2 cycles (IDLE + WRITE); WDONE in cycle 3 with stall = 0.
- mem_req deasserts on the edge following the final mem_ready; mem_addr advances on the edge after each accepted beat.
- Reset mid-REFILL: abort; the line remains invalid (valid cleared at miss); mem_req drops immediately.
- Reset mid-WRITE: the write is dropped; memory contents are undefined for that beat; the cache is not updated.
- Conflict miss on a valid line silently evicts it (write-through, never dirty).

## Test plan
- Reset, load 0x0000_0104 with memory words 0x100..0x10C = A,B,C,D and always-ready -> stall 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, cpu_rdata = B.
- Follow-up loads 0x100, 0x10C -> stall = 0, rdata A then D, mem_req stays 0.
- Store 0xDEADBEEF to 0x108 (hit) -> one write beat at 0x108, stall 2 cycles, WDONE; reload 0x108 hits returning 0xDEADBEEF.
- Store to 0x2000 (miss) -> write beat issued, no allocation; load 0x2000 then refills from memory (5 stall cycles).
- Conflict: load 0x104 then 0x1104 (same index, different tag) -> second refill evicts; load 0x104 misses again.
- Assert rst during beat 2 of a refill with mem_ready throttled (every other cycle) -> mem_req = 0 immediately, state IDLE, reload of same address performs a full 4-beat refill.
